// File: rtl/stream_distributor_pkg.sv
// Shared constants for the stream distributor: per-output buffer depth and
// the select encodings that steer a beat to output 0 or output 1.
package stream_distributor_pkg;

    localparam int STREAM_BUF_DEPTH = 2;
    localparam int STREAM_CNT_W     = $clog2(STREAM_BUF_DEPTH + 1);

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/stream_distributor_skid_buffer.sv
// stream_skid_buffer: 2-entry FIFO (head + second register) with a registered
// valid/data interface on the output side and a full flag for upstream steering.
module stream_skid_buffer
    import stream_distributor_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iPushData,
    output logic             oFull,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oData
);

    logic [STREAM_CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0]        head_q, head_d;
    logic [WIDTH-1:0]        second_q, second_d;
    logic                    push_ok;
    logic                    pop;

    assign oFull   = (count_q == STREAM_CNT_W'(STREAM_BUF_DEPTH));
    assign oValid  = (count_q != '0);
    assign oData   = head_q;
    assign push_ok = iPush && !oFull;
    assign pop     = oValid && iReady;

    always_comb begin
        count_d  = count_q;
        head_d   = head_q;
        second_d = second_q;
        if (push_ok && pop) begin
            // At count 1 the incoming beat becomes head directly.
            if (count_q == STREAM_CNT_W'(1)) begin
                head_d = iPushData;
            end else begin
                head_d   = second_q;
                second_d = iPushData;
            end
        end else if (pop) begin
            head_d  = second_q;
            count_d = count_q - STREAM_CNT_W'(1);
        end else if (push_ok) begin
            if (count_q == '0) begin
                head_d = iPushData;
            end else begin
                second_d = iPushData;
            end
            count_d = count_q + STREAM_CNT_W'(1);
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            count_q  <= '0;
            head_q   <= '0;
            second_q <= '0;
        end else begin
            count_q  <= count_d;
            head_q   <= head_d;
            second_q <= second_d;
        end
    end

endmodule

// File: rtl/stream_distributor.sv
// Splits one valid/ready stream into two buffered output streams by select bit.
// Optional STREAM_DISTRIBUTOR_BROADCAST_EN adds iBroadcast_AS to push into both.
module stream_distributor
    import stream_distributor_pkg::*;
#(
    parameter int WIDTH0 = 32,
    parameter int WIDTH1 = 32
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iValid_AS,
    output logic                     oReady_AS,
    input  logic                     iSelect_AS,
`ifdef STREAM_DISTRIBUTOR_BROADCAST_EN
    input  logic                     iBroadcast_AS,
`endif
    input  logic [WIDTH1+WIDTH0-1:0] iData_AS,
    output logic                     oValid_BM0,
    input  logic                     iReady_BM0,
    output logic [WIDTH0-1:0]        oData_BM0,
    output logic                     oValid_BM1,
    input  logic                     iReady_BM1,
    output logic [WIDTH1-1:0]        oData_BM1
);

    logic full_0, full_1;
    logic bcast;
    logic ready;
    logic push_0, push_1;

`ifdef STREAM_DISTRIBUTOR_BROADCAST_EN
    assign bcast = iBroadcast_AS;
`else
    assign bcast = 1'b0;
`endif

    // Ready depends only on buffer fullness, never on downstream ready.
    always_comb begin
        if (bcast) begin
            ready = !full_0 && !full_1;
        end else if (iSelect_AS == SEL_OUT1) begin
            ready = !full_1;
        end else begin
            ready = !full_0;
        end
    end

    assign oReady_AS = ready && !iRST;
    assign push_0    = iValid_AS && oReady_AS && (bcast || iSelect_AS == SEL_OUT0);
    assign push_1    = iValid_AS && oReady_AS && (bcast || iSelect_AS == SEL_OUT1);

    stream_skid_buffer #(.WIDTH(WIDTH0)) u_buf0 (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iPush     (push_0),
        .iPushData (iData_AS[WIDTH0-1:0]),
        .oFull     (full_0),
        .oValid    (oValid_BM0),
        .iReady    (iReady_BM0),
        .oData     (oData_BM0)
    );

    stream_skid_buffer #(.WIDTH(WIDTH1)) u_buf1 (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iPush     (push_1),
        .iPushData (iData_AS[WIDTH1+WIDTH0-1:WIDTH0]),
        .oFull     (full_1),
        .oValid    (oValid_BM1),
        .iReady    (iReady_BM1),
        .oData     (oData_BM1)
    );

endmodule

// File: tb/tb_stream_distributor.sv
// Directed, table-driven bench for stream_distributor (both buffers, ready
// steering, backpressure, isolation, reset) plus broadcast when enabled.
module tb_stream_distributor;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic        sel;
    logic        bcast;
    logic [63:0] data;
    logic        v0, v1, r0, r1;
    logic [31:0] d0, d1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stream_distributor #(.WIDTH0(32), .WIDTH1(32)) dut (
        .iCLK          (clk),
        .iRST          (rst),
        .iValid_AS     (valid),
        .oReady_AS     (ready),
        .iSelect_AS    (sel),
`ifdef STREAM_DISTRIBUTOR_BROADCAST_EN
        .iBroadcast_AS (bcast),
`endif
        .iData_AS      (data),
        .oValid_BM0    (v0),
        .iReady_BM0    (r0),
        .oData_BM0     (d0),
        .oValid_BM1    (v1),
        .iReady_BM1    (r1),
        .oData_BM1     (d1)
    );

    typedef struct {
        logic        v;
        logic        s;
        logic [63:0] d;
        logic        r0;
        logic        r1;
        logic        e_rdy;
        logic        e_v0;
        logic [31:0] e_d0;
        logic        e_v1;
        logic [31:0] e_d1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic s, input logic [63:0] d,
                       input logic a0, input logic a1, input logic e_rdy,
                       input logic e_v0, input logic [31:0] e_d0,
                       input logic e_v1, input logic [31:0] e_d1);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.r0 = a0; t.r1 = a1; t.e_rdy = e_rdy;
        t.e_v0 = e_v0; t.e_d0 = e_d0; t.e_v1 = e_v1; t.e_d1 = e_d1;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_v0, input logic [31:0] e_d0,
                              input logic e_v1, input logic [31:0] e_d1);
        check({tag, " v0"}, 64'(v0), 64'(e_v0));
        if (e_v0) check({tag, " d0"}, 64'(d0), 64'(e_d0));
        check({tag, " v1"}, 64'(v1), 64'(e_v1));
        if (e_v1) check({tag, " d1"}, 64'(d1), 64'(e_d1));
    endtask

    initial begin
        rst = 1'b1; valid = 1'b1; sel = 1'b0; bcast = 1'b0;
        data = 64'h0000_0002_0000_0001; r0 = 1'b1; r1 = 1'b1;

        // Reset held 3 cycles with a valid beat offered.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("rst%0d rdy", i), 64'(ready), 64'd0);
            check($sformatf("rst%0d v0", i), 64'(v0), 64'd0);
            check($sformatf("rst%0d v1", i), 64'(v1), 64'd0);
        end
        check("rst d0", 64'(d0), 64'd0);
        check("rst d1", 64'(d1), 64'd0);
        rst = 1'b0; valid = 1'b0;
        #1 check("post-rst rdy", 64'(ready), 64'd1);

        // routing
        add(1, 0, 64'h0000_0002_0000_0001, 1, 1, 1, 1, 32'h1, 0, 0);
        add(1, 1, 64'h0000_0004_0000_0003, 1, 1, 1, 0, 0, 1, 32'h4);
        add(0, 0, 64'h0,                   1, 1, 1, 0, 0, 0, 0);
        // backpressure on output 0
        add(1, 0, 64'h0000_0000_0000_0001, 0, 1, 1, 1, 32'h1, 0, 0);
        add(1, 0, 64'h0000_0000_0000_0002, 0, 1, 1, 1, 32'h1, 0, 0);
        add(1, 0, 64'h0000_0000_0000_0003, 0, 1, 0, 1, 32'h1, 0, 0);
        add(1, 0, 64'h0000_0000_0000_0003, 1, 1, 0, 1, 32'h2, 0, 0);
        add(1, 0, 64'h0000_0000_0000_0003, 1, 1, 1, 1, 32'h3, 0, 0);
        add(0, 0, 64'h0,                   1, 1, 1, 0, 0, 0, 0);
        // isolation: output 0 full and stalled, output 1 streaming
        add(1, 0, 64'h0000_0000_0000_0010, 0, 1, 1, 1, 32'h10, 0, 0);
        add(1, 0, 64'h0000_0000_0000_0011, 0, 1, 1, 1, 32'h10, 0, 0);
        add(1, 1, 64'h0000_0021_0000_0000, 0, 1, 1, 1, 32'h10, 1, 32'h21);
        add(1, 1, 64'h0000_0022_0000_0000, 0, 1, 1, 1, 32'h10, 1, 32'h22);
        add(1, 1, 64'h0000_0023_0000_0000, 0, 1, 1, 1, 32'h10, 1, 32'h23);
        add(1, 0, 64'h0000_0000_0000_0012, 0, 1, 0, 1, 32'h10, 0, 0);
        add(0, 0, 64'h0,                   0, 0, 0, 1, 32'h10, 0, 0);
        add(0, 1, 64'h0,                   0, 0, 1, 1, 32'h10, 0, 0);
        add(0, 0, 64'h0,                   1, 0, 0, 1, 32'h11, 0, 0);
        add(0, 0, 64'h0,                   1, 0, 1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            valid = vecs[i].v; sel = vecs[i].s; data = vecs[i].d;
            r0 = vecs[i].r0; r1 = vecs[i].r1;
            #1 check($sformatf("vec%0d rdy", i), 64'(ready), 64'(vecs[i].e_rdy));
            @(posedge clk); #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_v0, vecs[i].e_d0,
                       vecs[i].e_v1, vecs[i].e_d1);
        end

        // Mid-operation reset with both buffers holding two beats.
        r0 = 1'b0; r1 = 1'b0; valid = 1'b1;
        sel = 1'b0; data = 64'h0000_0000_0000_00A1; @(posedge clk); #1;
        data = 64'h0000_0000_0000_00A2;             @(posedge clk); #1;
        sel = 1'b1; data = 64'h0000_00B1_0000_0000; @(posedge clk); #1;
        data = 64'h0000_00B2_0000_0000;             @(posedge clk); #1;
        check_outs("filled", 1, 32'hA1, 1, 32'hB1);
        valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("midrst rdy", 64'(ready), 64'd0);
        check_outs("midrst", 0, 0, 0, 0);
        rst = 1'b0; r0 = 1'b1; r1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_outs($sformatf("postrst%0d", i), 0, 0, 0, 0);
        end

`ifdef STREAM_DISTRIBUTOR_BROADCAST_EN
        bcast = 1'b1; valid = 1'b1; sel = 1'b0; data = 64'h0000_00BB_0000_00AA;
        #1 check("bc rdy", 64'(ready), 64'd1);
        @(posedge clk); #1;
        check_outs("bc", 1, 32'hAA, 1, 32'hBB);
        bcast = 1'b0; sel = 1'b1; r1 = 1'b0;
        data = 64'h0000_00C1_0000_0000; @(posedge clk); #1;
        data = 64'h0000_00C2_0000_0000; @(posedge clk); #1;
        valid = 1'b0; bcast = 1'b1; sel = 1'b0;
        #1 check("bc full1 rdy", 64'(ready), 64'd0);
        check("bc full1 v0", 64'(v0), 64'd0);
        bcast = 1'b0;
        #1 check("bc off rdy", 64'(ready), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
